// File: rtl/conv3x3_mac_if.sv
// Streaming bus of the 3x3 convolution MAC: serial coefficient load, window in, result out.
interface conv3x3_mac_if #(
  parameter int DATA_WIDHT = 32
);
  logic                  Load_Start;
  logic [DATA_WIDHT-1:0] Weight_In;
  logic                  Weight_Valid;
  logic                  Weights_Ready;
  logic [DATA_WIDHT-1:0] Data_In1;
  logic [DATA_WIDHT-1:0] Data_In2;
  logic [DATA_WIDHT-1:0] Data_In3;
  logic [DATA_WIDHT-1:0] Data_In4;
  logic [DATA_WIDHT-1:0] Data_In5;
  logic [DATA_WIDHT-1:0] Data_In6;
  logic [DATA_WIDHT-1:0] Data_In7;
  logic [DATA_WIDHT-1:0] Data_In8;
  logic [DATA_WIDHT-1:0] Data_In9;
  logic                  Valid_In;
  logic [DATA_WIDHT-1:0] Data_Out;
  logic                  Valid_Out;

  modport master (
    output Load_Start, Weight_In, Weight_Valid,
    output Data_In1, Data_In2, Data_In3, Data_In4, Data_In5,
    output Data_In6, Data_In7, Data_In8, Data_In9, Valid_In,
    input  Weights_Ready, Data_Out, Valid_Out
  );

  modport slave (
    input  Load_Start, Weight_In, Weight_Valid,
    input  Data_In1, Data_In2, Data_In3, Data_In4, Data_In5,
    input  Data_In6, Data_In7, Data_In8, Data_In9, Valid_In,
    output Weights_Ready, Data_Out, Valid_Out
  );
endinterface

// File: rtl/conv3x3_mac.sv
// 3x3 signed fixed-point convolution MAC, 4-stage pipeline, 1 window/clk.
// Optional CONV3X3_RELU_EN: clamp negative results to zero in the last stage.
module conv3x3_mac #(
  parameter int DATA_WIDHT = 32,
  parameter int FRAC_BITS  = 8
) (
  input  logic           clk,
  input  logic           rst,
  conv3x3_mac_if.slave   bus
);
  localparam int DW = DATA_WIDHT;
  localparam int PW = 2 * DW;
  localparam int RW = PW + 2;
  localparam int AW = PW + 4;

  localparam logic signed [AW-1:0] HALF   = {{(AW-1){1'b0}}, 1'b1} << (FRAC_BITS - 1);
  localparam logic signed [AW-1:0] SAT_HI = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_LO = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic [DW-1:0]        OUT_HI = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0]        OUT_LO = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic {LOAD, RUN} state_t;

  state_t                 state;
  logic [3:0]             cnt;
  logic signed [DW-1:0]   w [9];
  logic signed [DW-1:0]   bias;
  logic                   weights_ready_q;

  logic signed [DW-1:0]   x [9];
  logic signed [PW-1:0]   prod [9];
  logic signed [RW-1:0]   row [3];
  logic signed [AW-1:0]   total;
  logic [3:0]             vld;
  logic [DW-1:0]          data_out_q;

  logic signed [AW-1:0]   bias_ext;
  logic signed [AW-1:0]   rounded;
  logic signed [AW-1:0]   shifted;
  logic [DW-1:0]          result;

  always_comb begin
    x[0] = bus.Data_In1;
    x[1] = bus.Data_In2;
    x[2] = bus.Data_In3;
    x[3] = bus.Data_In4;
    x[4] = bus.Data_In5;
    x[5] = bus.Data_In6;
    x[6] = bus.Data_In7;
    x[7] = bus.Data_In8;
    x[8] = bus.Data_In9;
  end

  // Coefficient loader: words 0..8 are weights, word 9 is the bias.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= LOAD;
      cnt             <= '0;
      bias            <= '0;
      weights_ready_q <= 1'b0;
      for (int unsigned i = 0; i < 9; i++) w[i] <= '0;
    end else if (bus.Load_Start) begin
      state           <= LOAD;
      cnt             <= '0;
      weights_ready_q <= 1'b0;
    end else if (state == LOAD && bus.Weight_Valid) begin
      if (cnt == 4'd9) begin
        bias            <= bus.Weight_In;
        cnt             <= '0;
        state           <= RUN;
        weights_ready_q <= 1'b1;
      end else begin
        w[cnt] <= bus.Weight_In;
        cnt    <= cnt + 4'd1;
      end
    end
  end

  always_comb begin
    bias_ext = AW'(bias) <<< FRAC_BITS;
    rounded  = total + HALF;
    shifted  = rounded >>> FRAC_BITS;
    if (shifted > SAT_HI)      result = OUT_HI;
    else if (shifted < SAT_LO) result = OUT_LO;
    else                       result = shifted[DW-1:0];
`ifdef CONV3X3_RELU_EN
    if (result[DW-1]) result = '0;
`endif
  end

  // Data stages run freely; only the valid pipe decides what reaches Data_Out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 9; i++) prod[i] <= '0;
      for (int unsigned r = 0; r < 3; r++) row[r] <= '0;
      total      <= '0;
      vld        <= '0;
      data_out_q <= '0;
    end else begin
      for (int unsigned i = 0; i < 9; i++) prod[i] <= PW'(x[i]) * PW'(w[i]);
      for (int unsigned r = 0; r < 3; r++)
        row[r] <= RW'(prod[3*r]) + RW'(prod[3*r+1]) + RW'(prod[3*r+2]);
      total <= AW'(row[0]) + AW'(row[1]) + AW'(row[2]) + bias_ext;
      if (bus.Load_Start) vld <= '0;
      else                vld <= {vld[2:0], bus.Valid_In && (state == RUN)};
      if (vld[2] && !bus.Load_Start) data_out_q <= result;
    end
  end

  assign bus.Data_Out      = data_out_q;
  assign bus.Valid_Out     = vld[3];
  assign bus.Weights_Ready = weights_ready_q;
endmodule

// File: tb/tb_conv3x3_mac.sv
// Self-checking bench for conv3x3_mac: constant vector table, corner sequences, random vs model.
module tb_conv3x3_mac;
  localparam int DW = 32;
  localparam int FB = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv3x3_mac_if #(.DATA_WIDHT(DW)) bus ();
  conv3x3_mac #(.DATA_WIDHT(DW), .FRAC_BITS(FB)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] w1, wr, b, x1, xr, exp;
  } vec_t;
  vec_t tbl [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] post(input logic [31:0] v);
`ifdef CONV3X3_RELU_EN
    return v[31] ? 32'h0 : v;
`else
    return v;
`endif
  endfunction

  // Mathematical reference: exact sum, round half up via floor division, clamp.
  function automatic logic [31:0] ref_conv(input logic [31:0] w [9], input logic [31:0] b,
                                           input logic [31:0] x [9]);
    logic signed [127:0] acc, q, r;
    acc = 0;
    for (int i = 0; i < 9; i++) acc += 128'($signed(w[i])) * 128'($signed(x[i]));
    acc += 128'($signed(b)) * 256;
    q = acc + 128;
    if (q >= 0) r = q / 256;
    else        r = -((-q + 255) / 256);
    if (r > 128'sh7FFFFFFF)       r = 128'sh7FFFFFFF;
    else if (r < -128'sh80000000) r = -128'sh80000000;
    return post(r[31:0]);
  endfunction

  task automatic idle();
    bus.Load_Start = 1'b0; bus.Weight_In = '0; bus.Weight_Valid = 1'b0; bus.Valid_In = 1'b0;
    bus.Data_In1 = '0; bus.Data_In2 = '0; bus.Data_In3 = '0; bus.Data_In4 = '0; bus.Data_In5 = '0;
    bus.Data_In6 = '0; bus.Data_In7 = '0; bus.Data_In8 = '0; bus.Data_In9 = '0;
  endtask

  task automatic set_window(input logic [31:0] x [9]);
    bus.Data_In1 = x[0]; bus.Data_In2 = x[1]; bus.Data_In3 = x[2];
    bus.Data_In4 = x[3]; bus.Data_In5 = x[4]; bus.Data_In6 = x[5];
    bus.Data_In7 = x[6]; bus.Data_In8 = x[7]; bus.Data_In9 = x[8];
  endtask

  task automatic load(input logic [31:0] w [9], input logic [31:0] b);
    @(negedge clk); bus.Load_Start = 1'b1; bus.Weight_Valid = 1'b0;
    @(negedge clk); bus.Load_Start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.Weight_Valid = 1'b1;
      bus.Weight_In    = (i < 9) ? w[i] : b;
      @(negedge clk);
    end
    bus.Weight_Valid = 1'b0;
  endtask

  // Single window; bounded watch of 8 edges, edge that samples Valid_In counts as 1.
  task automatic one_window(input logic [31:0] x [9], output int lat, output int nv,
                            output logic [31:0] d);
    @(negedge clk); set_window(x); bus.Valid_In = 1'b1;
    lat = -1; nv = 0; d = '0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1; bus.Valid_In = 1'b0;
      if (bus.Valid_Out) begin
        nv++;
        if (lat < 0) begin lat = k; d = bus.Data_Out; end
      end
    end
  endtask

  task automatic tick(inout int nv);
    @(posedge clk); #1;
    if (bus.Valid_Out) nv++;
    @(negedge clk);
  endtask

  task automatic random_run(input int ncyc, input bit wide);
    logic [31:0] w [9];
    logic [31:0] x [9];
    logic [31:0] b;
    logic [31:0] q [$];
    for (int i = 0; i < 9; i++) w[i] = wide ? $urandom : 32'($urandom_range(0, 1023)) - 32'd512;
    b = wide ? $urandom : 32'($urandom_range(0, 4095)) - 32'd2048;
    load(w, b);
    check("rand_ready", bus.Weights_Ready, 1);
    for (int c = 0; c < ncyc + 8; c++) begin
      @(negedge clk);
      if (c < ncyc && $urandom_range(0, 3) != 0) begin
        for (int i = 0; i < 9; i++) x[i] = wide ? $urandom : 32'($urandom_range(0, 65535)) - 32'h8000;
        set_window(x);
        bus.Valid_In = 1'b1;
        q.push_back(ref_conv(w, b, x));
      end else begin
        bus.Valid_In = 1'b0;
      end
      @(posedge clk); #1;
      if (bus.Valid_Out) begin
        if (q.size() == 0) check("rand_extra_out", 1, 0);
        else               check("rand_data", bus.Data_Out, q.pop_front());
      end
    end
    bus.Valid_In = 1'b0;
    check("rand_drain", q.size(), 0);
  endtask

  initial begin
    logic [31:0] w [9];
    logic [31:0] x [9];
    logic [31:0] d;
    logic [31:0] outs [$];
    int          lat, nv, first, last;

    tbl[0] = '{32'h100, 32'h100,  32'h0,        32'h100,      32'h100,      32'h900};
    tbl[1] = '{32'h80,  32'h0,    32'h0,        32'h1,        32'h0,        32'h1};
    tbl[2] = '{32'h0,   32'h0,    32'hFFFFFF00, 32'h0,        32'h0,        post(32'hFFFFFF00)};
    tbl[3] = '{32'h7F00, 32'h7F00, 32'h0,       32'h7FFFFF00, 32'h7FFFFF00, 32'h7FFFFFFF};
    tbl[4] = '{32'h7F00, 32'h7F00, 32'h0,       32'h80000000, 32'h80000000, post(32'h80000000)};
    tbl[5] = '{32'h80,  32'h0,    32'h0,        32'hFFFFFFFF, 32'h0,        32'h0};
    tbl[6] = '{32'h100, 32'h0,    32'h1,        32'h7FFFFFFF, 32'h0,        32'h7FFFFFFF};
    tbl[7] = '{32'h180, 32'h0,    32'h0,        32'h1,        32'h0,        32'h2};

    // Reset is visible without any clock edge.
    idle();
    rst = 1'b1;
    #1;
    check("reset_data_out", bus.Data_Out, 0);
    check("reset_valid_out", bus.Valid_Out, 0);
    check("reset_weights_ready", bus.Weights_Ready, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 8; v++) begin
      w[0] = tbl[v].w1; x[0] = tbl[v].x1;
      for (int i = 1; i < 9; i++) begin w[i] = tbl[v].wr; x[i] = tbl[v].xr; end
      load(w, tbl[v].b);
      check($sformatf("vec%0d_ready", v), bus.Weights_Ready, 1);
      one_window(x, lat, nv, d);
      check($sformatf("vec%0d_latency", v), lat, 4);
      check($sformatf("vec%0d_pulses", v), nv, 1);
      check($sformatf("vec%0d_data", v), d, tbl[v].exp);
    end

    // Throughput: 20 back-to-back windows, weights 1.0.
    for (int i = 0; i < 9; i++) w[i] = 32'h100;
    load(w, 32'h0);
    first = -1; last = -1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (c < 20) begin
        for (int i = 0; i < 9; i++) x[i] = 32'(c + 1) * 32'h100;
        set_window(x);
        bus.Valid_In = 1'b1;
      end else bus.Valid_In = 1'b0;
      @(posedge clk); #1;
      if (bus.Valid_Out) begin
        outs.push_back(bus.Data_Out);
        if (first < 0) first = c;
        last = c;
      end
    end
    check("tput_count", outs.size(), 20);
    check("tput_first_cycle", first, 3);
    check("tput_contiguous", last - first, 19);
    for (int k = 1; k <= 20 && outs.size() > 0; k++) check($sformatf("tput_data%0d", k), outs.pop_front(), 32'(k) * 32'h900);

    // Load_Start with three results in flight; same-cycle Weight_Valid must be ignored.
    for (int i = 0; i < 9; i++) x[i] = 32'h100;
    nv = 0;
    @(negedge clk); set_window(x); bus.Valid_In = 1'b1;
    tick(nv); tick(nv); tick(nv);
    bus.Valid_In = 1'b0; bus.Load_Start = 1'b1; bus.Weight_Valid = 1'b1; bus.Weight_In = 32'hDEAD00;
    tick(nv);
    bus.Load_Start = 1'b0; bus.Weight_Valid = 1'b0;
    check("flush_weights_ready", bus.Weights_Ready, 0);
    bus.Valid_In = 1'b1;
    for (int c = 0; c < 6; c++) tick(nv);
    for (int i = 0; i < 10; i++) begin
      bus.Weight_Valid = 1'b1;
      bus.Weight_In = (i < 9) ? 32'h200 : 32'h0;
      if (i == 9) check("reload_not_ready_after_9", bus.Weights_Ready, 0);
      tick(nv);
    end
    bus.Valid_In = 1'b0; bus.Weight_Valid = 1'b0;
    check("reload_ready_after_10", bus.Weights_Ready, 1);
    for (int c = 0; c < 5; c++) tick(nv);
    check("flush_no_valid_out", nv, 0);
    one_window(x, lat, nv, d);
    check("reload_latency", lat, 4);
    check("reload_data", d, 32'h1200);

    random_run(200, 1'b0);
    random_run(100, 1'b1);

    // Asynchronous reset mid-stream clears everything between edges.
    for (int i = 0; i < 9; i++) w[i] = 32'h100;
    load(w, 32'h0);
    @(negedge clk); set_window(x); bus.Valid_In = 1'b1;
    @(posedge clk); #1; bus.Valid_In = 1'b0;
    @(posedge clk); @(posedge clk); @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid_out", bus.Valid_Out, 0);
    check("async_rst_data_out", bus.Data_Out, 0);
    check("async_rst_weights_ready", bus.Weights_Ready, 0);
    @(negedge clk); rst = 1'b0;
    nv = 0;
    for (int c = 0; c < 6; c++) tick(nv);
    check("after_rst_no_output", nv, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
